// File: rtl/axis_gmii_tx_pkg.sv
// Shared constants and FSM state type for the AXI4-Stream to GMII transmitter.
package axis_gmii_tx_pkg;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_WAIT_END,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/axis_gmii_tx_if.sv
// AXI4-Stream byte channel feeding the GMII transmitter.
interface axis_gmii_tx_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/axis_gmii_tx_lfsr.sv
// Combinational Galois LFSR step: advances state_in by DATA_WIDTH input bits.
module axis_gmii_tx_lfsr #(
  parameter int unsigned                LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]      LFSR_POLY  = 32'h04c11db7,
  parameter bit                         REVERSE    = 1'b1,
  parameter int unsigned                DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;

  // Reflected mode shifts right and consumes data LSB first.
  always_comb begin
    s  = state_in;
    fb = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = s >> 1;
        if (fb) s = s ^ POLY_REV;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = s << 1;
        if (fb) s = s ^ LFSR_POLY;
      end
    end
    state_out = s;
  end

endmodule

// File: rtl/axis_gmii_tx.sv
// AXI4-Stream to GMII/MII frame transmitter: preamble, SFD, payload, padding, FCS, IFG.
module axis_gmii_tx
  import axis_gmii_tx_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_gmii_tx_if.slave        s_axis,
  output logic [7:0]           gmii_txd,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  input  logic                 clk_enable,
  input  logic                 mii_select,
  input  logic [7:0]           ifg_delay,
  output logic                 start_packet,
  output logic                 error_underflow
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("axis_gmii_tx: DATA_WIDTH must be 8");
  end

  localparam logic [15:0] MIN_DATA_LEN = 16'(MIN_FRAME_LENGTH - 4);

  tx_state_t   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [31:0] crc_q, crc_d, crc_next, fcs_word;
  logic        tuser_q, tuser_d;
  logic        phase_q;
  logic [7:0]  held_q;
  logic [7:0]  crc_in, byte_d;
  logic        en_d, er_d, start_d, uflow_d;
  logic        step;

  assign step = clk_enable && (!mii_select || !phase_q);
  assign s_axis.tready = clk_enable &&
                         ((state_q == ST_WAIT_END) || (state_q == ST_PAYLOAD && step));
  assign fcs_word = tuser_q ? crc_q : ~crc_q;

  axis_gmii_tx_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (32'h04c11db7),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .data_in   (crc_in),
    .state_in  (crc_q),
    .state_out (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    frame_len_d = frame_len_q;
    crc_d       = crc_q;
    tuser_d     = tuser_q;
    crc_in      = '0;
    byte_d      = '0;
    en_d        = 1'b0;
    er_d        = 1'b0;
    start_d     = 1'b0;
    uflow_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        crc_d       = '1;
        frame_len_d = '0;
        cnt_d       = '0;
        if (step && s_axis.tvalid) begin
          byte_d  = ETH_PRE;
          en_d    = 1'b1;
          start_d = 1'b1;
          cnt_d   = 3'd1;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: if (step) begin
        en_d = 1'b1;
        if (cnt_q == 3'd7) begin
          byte_d  = ETH_SFD;
          state_d = ST_PAYLOAD;
        end else begin
          byte_d = ETH_PRE;
          cnt_d  = cnt_q + 3'd1;
        end
      end
      ST_PAYLOAD: if (step) begin
        en_d = 1'b1;
        if (s_axis.tvalid) begin
          byte_d      = s_axis.tdata;
          crc_in      = s_axis.tdata;
          crc_d       = crc_next;
          frame_len_d = (frame_len_q == '1) ? frame_len_q : frame_len_q + 16'd1;
          if (s_axis.tlast) begin
            tuser_d = s_axis.tuser;
            cnt_d   = '0;
            state_d = (ENABLE_PADDING != 0 && frame_len_d < MIN_DATA_LEN) ? ST_PAD : ST_FCS;
          end
        end else begin
          er_d    = 1'b1;
          uflow_d = 1'b1;
          state_d = ST_WAIT_END;
        end
      end
      ST_PAD: if (step) begin
        en_d        = 1'b1;
        crc_d       = crc_next;
        frame_len_d = (frame_len_q == '1) ? frame_len_q : frame_len_q + 16'd1;
        if (frame_len_d >= MIN_DATA_LEN) begin
          cnt_d   = '0;
          state_d = ST_FCS;
        end
      end
      ST_FCS: if (step) begin
        en_d   = 1'b1;
        byte_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q[1:0] == 2'd3) begin
          ifg_cnt_d = (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
          state_d   = ST_IFG;
        end
      end
      // Draining is not tied to the nibble phase so no beat is stranded in MII mode.
      ST_WAIT_END: if (clk_enable && s_axis.tvalid && s_axis.tlast) begin
        ifg_cnt_d = (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
        state_d   = ST_IFG;
      end
      ST_IFG: if (step) begin
        if (ifg_cnt_q <= 8'd1) state_d = ST_IDLE;
        else                   ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      ifg_cnt_q       <= '0;
      frame_len_q     <= '0;
      crc_q           <= '1;
      tuser_q         <= 1'b0;
      phase_q         <= 1'b0;
      held_q          <= '0;
      gmii_txd        <= '0;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else if (clk_enable) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ifg_cnt_q       <= ifg_cnt_d;
      frame_len_q     <= frame_len_d;
      crc_q           <= crc_d;
      tuser_q         <= tuser_d;
      phase_q         <= mii_select && !phase_q && !(state_q == ST_IDLE && !s_axis.tvalid);
      start_packet    <= start_d;
      error_underflow <= uflow_d;
      if (step) begin
        held_q     <= byte_d;
        gmii_tx_en <= en_d;
        gmii_tx_er <= er_d;
        gmii_txd   <= mii_select ? {4'b0000, byte_d[3:0]} : byte_d;
      end else begin
        gmii_txd <= {4'b0000, held_q[7:4]};
      end
    end
  end

endmodule
